// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU with stall and done handshake
module div_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  aluop,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_DIVU = 5'b01110;
  localparam logic [4:0] OP_REM  = 5'b01111;
  localparam logic [4:0] OP_REMU = 5'b10000;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, next;
  logic [4:0]  cnt;
  logic        op_rem, sign1, sign2;
  logic [31:0] mag2, quo, rem;
  logic        is_div, in_signed, in_rem, accept, zero_div, ovf, special;
  logic [31:0] spec_val;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] quo_nx, rem_nx, fin;
  assign is_div    = aluop == OP_DIV || aluop == OP_DIVU || aluop == OP_REM || aluop == OP_REMU;
  assign in_signed = aluop == OP_DIV || aluop == OP_REM;
  assign in_rem    = aluop == OP_REM || aluop == OP_REMU;
  assign accept    = state == IDLE && start && !flush && is_div;
  assign zero_div  = data2 == '0;
  assign ovf       = in_signed && data1 == 32'h8000_0000 && data2 == 32'hffff_ffff;
  assign special   = zero_div || ovf;
  assign spec_val  = zero_div ? (in_rem ? data1 : 32'hffff_ffff) : (in_rem ? 32'h0 : 32'h8000_0000);
  // One restoring step: the dividend is shifted out of quo MSB-first while quotient bits fill from the bottom.
  assign shifted = {rem, quo[31]};
  assign ge      = shifted >= {1'b0, mag2};
  assign rem_nx  = ge ? shifted[31:0] - mag2 : shifted[31:0];
  assign quo_nx  = {quo[30:0], ge};
  assign fin     = op_rem ? (sign1 ? -rem_nx : rem_nx) : (sign1 ^ sign2 ? -quo_nx : quo_nx);
  assign busy    = accept || state == RUN;
  always_comb begin
    next = state;
    if (flush) next = IDLE;
    else if (accept) next = special ? FINISH : RUN;
    else if (state == RUN && cnt == 5'd0) next = FINISH;
    else if (state == FINISH) next = IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      op_rem <= 1'b0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      mag2   <= '0;
      quo    <= '0;
      rem    <= '0;
    end else begin
      done <= next == FINISH;
      if (accept) begin
        op_rem <= in_rem;
        sign1  <= in_signed && data1[31];
        sign2  <= in_signed && data2[31];
        quo    <= in_signed && data1[31] ? -data1 : data1;
        mag2   <= in_signed && data2[31] ? -data2 : data2;
        rem    <= '0;
        cnt    <= 5'd31;
        if (special) result <= spec_val;
      end else if (state == RUN && !flush) begin
        quo <= quo_nx;
        rem <= rem_nx;
        cnt <= cnt - 5'd1;
        if (cnt == 5'd0) result <= fin;
      end
    end
  end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the RV32M divide/remainder operations (DIV, DIVU, REM, REMU), which the single-cycle ALU path does not execute. It sits beside the ALU in the EX stage and accepts the operation code produced by the control unit together with the two register operands. It runs a 32-step restoring division, holds the pipeline through BUSY while it runs, and returns the sign-corrected quotient or remainder with a one-cycle DONE pulse.

## Interface
- No parameters; data width fixed at 32 bits.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  operation request, sampled each cycle.
- ALUOP  in  5  operation code:
  - 5'b01101 DIV
  - 5'b01110 DIVU
  - 5'b01111 REM
  - 5'b10000 REMU
  - any other code is not a divide operation.
- DATA1  in  32  dividend (rs1).
- DATA2  in  32  divisor (rs2).
- FLUSH  in  1  abort the current operation (branch/jump flush).
- BUSY  out  1  pipeline stall request.
- DONE  out  1  one-cycle pulse; RESULT is valid in this cycle.
- RESULT  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).

## Operation
- States: IDLE, RUN, FINISH.
- Accept condition: state = IDLE, START = 1, FLUSH = 0, and ALUOP is one of the four divide codes. When any of these fails, START is ignored, including during RUN and FINISH.
- On accept, the block latches:
  - the operation type;
  - the signs of DATA1 and DATA2 (signed operations only);
  - the magnitudes |DATA1| and |DATA2|. Unsigned operations use the raw values. Two's-complement negation is used, so 0x80000000 maps to magnitude 0x80000000, held as unsigned.
- Special cases are decided at accept time and go straight to FINISH:
  - Divisor = 0: quotient = 0xFFFFFFFF; remainder = DATA1 (unmodified, all four ops).
  - Signed overflow (DIV/REM with DATA1 = 0x80000000, DATA2 = 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Normal case: the state goes to RUN with a 5-bit step counter set to 31.
- Each RUN cycle:
  - shift the 33-bit partial remainder left, bringing in the next dividend bit (MSB first);
  - subtract the divisor magnitude;
  - if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0;
  - decrement the counter.
  - After the step with counter = 0, the state goes to FINISH.
- Entering FINISH, RESULT is registered as follows:
  - DIV: the quotient, negated if the latched signs differ.
  - REM: the remainder, negated if the dividend was negative.
  - DIVU/REMU: the raw quotient/remainder.
  - Special cases: the predetermined value.
- FINISH lasts exactly one cycle with DONE = 1, then the state returns to IDLE.
- RESULT holds its value until the next FINISH. It is not cleared on returning to IDLE.
- FLUSH = 1 in any state: the next state is IDLE, no DONE is produced, and RESULT is unchanged. FLUSH has priority over START.
- RESET = 1: the next state is IDLE, the counter is 0, and RESULT, DONE and BUSY are 0. RESET has priority over FLUSH and START, including mid-RUN.

## Timing
- Reset values: BUSY = 0, DONE = 0, RESULT = 0x00000000, state IDLE.
- BUSY is combinational: (accept condition true) OR (state = RUN). It is therefore already high in the request cycle, so the pipeline holds the instruction in EX.
- Normal operation, with the request accepted in cycle T:
  - RUN occupies cycles T+1 to T+32.
  - BUSY is high from T through T+32.
  - In cycle T+33, DONE = 1, BUSY = 0 and RESULT is valid. The pipeline captures RESULT at the T+33 edge.
  - Latency is 33 cycles.
- Special case accepted in cycle T: BUSY is high in T only; DONE and RESULT arrive in T+1.
- Back to back: the state is IDLE at T+34, and the earliest next accept is T+34.
- DONE is registered and is never high for two consecutive cycles.

## Test plan
- DIV 100 / 7, START in cycle T -> BUSY high T..T+32; DONE only at T+33 with RESULT = 14 (0x0000000E).
- REM 0xFFFFFFF9 (-7) / 2 -> RESULT = 0xFFFFFFFF (-1). DIV on the same operands -> 0xFFFFFFFD (-3). REMU 0xFFFFFFF9 / 2 -> 0x00000001.
- DIVU 0x12345678 / 0 -> DONE at T+1, RESULT = 0xFFFFFFFF. REM 0x12345678 / 0 -> RESULT = 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF -> DONE at T+1, RESULT = 0x80000000. REM on the same operands -> 0x00000000. DIVU on the same operands takes the full 33 cycles with RESULT = 0x00000000.
- Abort and reset mid-operation:
  - FLUSH at T+10 of a DIV -> no DONE, BUSY low from T+11, RESULT keeps its previous value. A new DIVU 9/3 then accepted -> RESULT = 3 after 33 cycles.
  - RESET at T+20 -> all outputs 0 from T+21.
- Ignored requests:
  - START with ALUOP = 5'b01001 (MUL) -> BUSY stays 0, no DONE.
  - START held high during RUN -> exactly one DONE per accepted request.
